// File: rtl/frame_reader_pkg.sv
// Shared types and constants for the frame buffer fill/read blocks.
// Optional prefetch in frame_reader is enabled with FRAME_READER_PREFETCH_EN.
package frame_reader_pkg;

  localparam int PIX_BITS       = 24;
  localparam int PIX_PER_ACCESS = 64;
  localparam int SLOT_BITS      = $clog2(PIX_PER_ACCESS);
  localparam int ACCESS_BITS    = PIX_PER_ACCESS * PIX_BITS;

  typedef logic [PIX_BITS-1:0] pixel_t;
  typedef logic [11:0]         coord_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/frame_reader_pixel_unpacker.sv
// Holds one or two SRAM access buffers and streams their pixels out with valid/ready.
// Buffers are filled and drained in ping-pong order; NBUF=2 is used when FRAME_READER_PREFETCH_EN is set.
module frame_reader_pixel_unpacker
  import frame_reader_pkg::*;
#(
  parameter int NBUF = 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   load,
  input  logic [ACCESS_BITS-1:0] load_data,
  input  logic                   pix_ready,
  output logic                   pix_valid,
  output pixel_t                 pix_data,
  output logic                   fire,
  output logic                   last_slot,
  output logic                   slot_zero,
  output logic                   free
);

  logic [NBUF-1:0]                full_reg;
  logic [NBUF-1:0]                full_next;
  logic [SLOT_BITS-1:0]           slot_reg;
  logic                           rd_sel_reg;
  logic                           wr_sel_reg;
  logic [NBUF-1:0]                rd_hit;
  logic [NBUF-1:0]                wr_hit;
  logic [NBUF-1:0][PIX_BITS-1:0]  word;

  genvar gi;
  generate
    for (gi = 0; gi < NBUF; gi++) begin : g_buf
      logic [ACCESS_BITS-1:0] buf_reg;

      assign rd_hit[gi] = (rd_sel_reg == 1'(gi));
      assign wr_hit[gi] = (wr_sel_reg == 1'(gi));
      // Word 0 of an access sits in the least significant pixel slot.
      assign word[gi]   = buf_reg[slot_reg*PIX_BITS +: PIX_BITS];

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          buf_reg <= '0;
        end else if (load && wr_hit[gi]) begin
          buf_reg <= load_data;
        end
      end
    end
  endgenerate

  always_comb begin
    pix_valid = |(full_reg & rd_hit);
    pix_data  = '0;
    for (int i = 0; i < NBUF; i++) begin
      if (rd_hit[i] && full_reg[i]) pix_data = word[i];
    end
  end

  assign fire      = pix_valid && pix_ready;
  assign last_slot = (slot_reg == SLOT_BITS'(PIX_PER_ACCESS - 1));
  assign slot_zero = (slot_reg == '0);
  assign free      = |(~full_reg & wr_hit);

  always_comb begin
    full_next = full_reg;
    if (fire && last_slot) full_next = full_next & ~rd_hit;
    if (load)              full_next = full_next | wr_hit;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      full_reg   <= '0;
      slot_reg   <= '0;
      rd_sel_reg <= 1'b0;
      wr_sel_reg <= 1'b0;
    end else begin
      full_reg <= full_next;
      if (load) wr_sel_reg <= (NBUF > 1) ? ~wr_sel_reg : 1'b0;
      if (fire) begin
        // Slot counter wraps to 0 naturally after the last pixel of an access.
        slot_reg <= slot_reg + SLOT_BITS'(1);
        if (last_slot) rd_sel_reg <= (NBUF > 1) ? ~rd_sel_reg : 1'b0;
      end
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Streams one frame-buffer layer out of SRAM in raster order as a valid/ready pixel stream.
// Define FRAME_READER_PREFETCH_EN to double-buffer accesses for a bubble-free stream.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int ADDR_BITS   = 30,
  parameter int FRAME_W     = 640,
  parameter int FRAME_H     = 480,
  parameter int LAYER1_BASE = 307200
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic                   layer_num,
  output logic                   busy,
  output logic                   done,
  output logic                   sram_read_en,
  output logic [ADDR_BITS-1:0]   sram_address,
  input  logic [ACCESS_BITS-1:0] sram_read_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output pixel_t                 pix_data,
  output coord_t                 pix_x,
  output coord_t                 pix_y
);

  localparam int TOTAL_ACC = FRAME_W * FRAME_H / PIX_PER_ACCESS;
  localparam int ACC_BITS  = $clog2(TOTAL_ACC + 1);

`ifdef FRAME_READER_PREFETCH_EN
  localparam int NBUF     = 2;
  localparam bit PREFETCH = 1'b1;
`else
  localparam int NBUF     = 1;
  localparam bit PREFETCH = 1'b0;
`endif

  state_t               state_reg;
  state_t               state_next;
  logic [ADDR_BITS-1:0] ptr_reg;
  coord_t               x_reg;
  coord_t               y_reg;
  logic [ACC_BITS-1:0]  acc_reg;

  logic fire;
  logic last_slot;
  logic slot_zero;
  logic free;
  logic frame_last;
  logic more_acc;

  frame_reader_pixel_unpacker #(
    .NBUF(NBUF)
  ) u_pixel_unpacker (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (state_reg == WAIT),
    .load_data (sram_read_data),
    .pix_ready (pix_ready),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .fire      (fire),
    .last_slot (last_slot),
    .slot_zero (slot_zero),
    .free      (free)
  );

  assign frame_last = fire && (x_reg == coord_t'(FRAME_W - 1)) && (y_reg == coord_t'(FRAME_H - 1));
  assign more_acc   = (acc_reg < ACC_BITS'(TOTAL_ACC));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start) state_next = REQ;
      REQ:    state_next = WAIT;
      WAIT:   state_next = STREAM;
      STREAM: begin
        if (frame_last) begin
          state_next = DONE;
        end else if (PREFETCH) begin
          // Fetch the next access once the current one has started draining.
          if (more_acc && free && pix_valid && !slot_zero) state_next = REQ;
        end else if (fire && last_slot) begin
          state_next = REQ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        ptr_reg <= layer_num ? ADDR_BITS'(LAYER1_BASE) : '0;
        x_reg   <= '0;
        y_reg   <= '0;
        acc_reg <= '0;
      end
      if (state_reg == REQ)  acc_reg <= acc_reg + ACC_BITS'(1);
      if (state_reg == WAIT) ptr_reg <= ptr_reg + ADDR_BITS'(PIX_PER_ACCESS);
      if (fire) begin
        if (x_reg == coord_t'(FRAME_W - 1)) begin
          x_reg <= '0;
          y_reg <= y_reg + coord_t'(1);
        end else begin
          x_reg <= x_reg + coord_t'(1);
        end
      end
    end
  end

  assign busy         = (state_reg == REQ) || (state_reg == WAIT) || (state_reg == STREAM);
  assign done         = (state_reg == DONE);
  assign sram_read_en = (state_reg == REQ);
  assign sram_address = ptr_reg;
  assign pix_x        = x_reg;
  assign pix_y        = y_reg;

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader on a small 128x2 frame; checks the pixel stream
// against a raster-order model and pins key values with literals.
module tb_frame_reader;

  localparam int FW    = 128;
  localparam int FH    = 2;
  localparam int NPIX  = FW * FH;
  localparam int NACC  = NPIX / 64;
  localparam int L1    = 1024;
`ifdef FRAME_READER_PREFETCH_EN
  localparam int RUN_EXP = 256;
`else
  localparam int RUN_EXP = 64;
`endif

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic          layer_num;
  logic          busy;
  logic          done;
  logic          sram_read_en;
  logic [29:0]   sram_address;
  logic [1535:0] sram_read_data = '0;
  logic          pix_valid;
  logic          pix_ready;
  logic [23:0]   pix_data;
  logic [11:0]   pix_x;
  logic [11:0]   pix_y;

  always #5 clk = ~clk;

  frame_reader #(
    .ADDR_BITS   (30),
    .FRAME_W     (FW),
    .FRAME_H     (FH),
    .LAYER1_BASE (L1)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start          (start),
    .layer_num      (layer_num),
    .busy           (busy),
    .done           (done),
    .sram_read_en   (sram_read_en),
    .sram_address   (sram_address),
    .sram_read_data (sram_read_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_data       (pix_data),
    .pix_x          (pix_x),
    .pix_y          (pix_y)
  );

  // SRAM contents: word n = n below layer 1, tagged with 0xC0 in the top byte above.
  function automatic logic [23:0] sram_word(input int a);
    return (a < L1) ? 24'(a) : (24'hC00000 | 24'(a));
  endfunction

  always @(posedge clk) begin
    if (sram_read_en) begin
      for (int j = 0; j < 64; j++) sram_read_data[j*24 +: 24] <= sram_word(int'(sram_address) + j);
    end
  end

  typedef struct {
    logic [23:0] data;
    int          x;
    int          y;
  } pix_t;

  pix_t exp_pix[$];
  int   exp_addr[$];

  int checks = 0;
  int errors = 0;
  int strobe_total = 0;
  int done_total = 0;
  int pix_total = 0;
  int frame_strobes, frame_pix, frame_y1_idx, max_run, run;
  int frame_first_addr, frame_first_data, frame_last_data;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic [23:0] h_data;
    logic [11:0] h_x, h_y;
    bit          stall;
    int          base;
    pix_t        e;
    stall = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        exp_pix.delete();
        exp_addr.delete();
        stall = 0;
        run   = 0;
      end else begin
        // Model: a start seen while idle queues the whole frame in raster order.
        if (start && !busy && !done) begin
          base = layer_num ? L1 : 0;
          exp_pix.delete();
          exp_addr.delete();
          for (int i = 0; i < NPIX; i++) begin
            e.data = sram_word(base + i);
            e.x    = i % FW;
            e.y    = i / FW;
            exp_pix.push_back(e);
          end
          for (int k = 0; k < NACC; k++) exp_addr.push_back(base + k * 64);
          frame_strobes = 0;
          frame_pix     = 0;
          frame_y1_idx  = -1;
          max_run       = 0;
          run           = 0;
        end
        if (sram_read_en) begin
          strobe_total++;
          if (frame_strobes == 0) frame_first_addr = int'(sram_address);
          frame_strobes++;
          check("strobe_expected", longint'(exp_addr.size() > 0), 1);
          if (exp_addr.size() > 0) check("strobe_addr", longint'(sram_address), longint'(exp_addr.pop_front()));
        end
        if (stall) check("stall_hold", longint'({pix_valid, pix_data, pix_x, pix_y}), longint'({1'b1, h_data, h_x, h_y}));
        if (pix_valid) begin
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
        if (pix_valid && pix_ready) begin
          check("pix_expected", longint'(exp_pix.size() > 0), 1);
          if (exp_pix.size() > 0) begin
            e = exp_pix.pop_front();
            check("pix_data", longint'(pix_data), longint'(e.data));
            check("pix_x", longint'(pix_x), longint'(e.x));
            check("pix_y", longint'(pix_y), longint'(e.y));
          end
          if (frame_pix == 0) frame_first_data = int'(pix_data);
          frame_last_data = int'(pix_data);
          if (pix_y == 12'd1 && frame_y1_idx < 0) frame_y1_idx = frame_pix;
          frame_pix++;
          pix_total++;
        end
        stall  = pix_valid && !pix_ready;
        h_data = pix_data;
        h_x    = pix_x;
        h_y    = pix_y;
        if (done) begin
          done_total++;
          check("done_busy_low", longint'(busy), 0);
          check("done_pix_left", longint'(exp_pix.size()), 0);
          check("done_addr_left", longint'(exp_addr.size()), 0);
        end
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_read_en"}, longint'(sram_read_en), 0);
    check({tag, "_address"}, longint'(sram_address), 0);
    check({tag, "_pix_valid"}, longint'(pix_valid), 0);
    check({tag, "_pix_data"}, longint'(pix_data), 0);
    check({tag, "_pix_x"}, longint'(pix_x), 0);
    check({tag, "_pix_y"}, longint'(pix_y), 0);
  endtask

  // mode 0: ready always high; mode 1: ready 1-on/2-off. poke pulses start while busy.
  task automatic run_frame(input string tag, input logic layer, input int mode, input bit poke,
                           input int exp_addr0, input int exp_data0, input int exp_datan, input int exp_run);
    int s0, p0, d0, cyc;
    s0 = strobe_total;
    p0 = pix_total;
    d0 = done_total;
    cyc = 0;
    @(posedge clk); #1;
    layer_num = layer;
    start     = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_total == d0 && cyc < 5000) begin
      pix_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      start     = poke && (cyc % 37 == 5);
      @(posedge clk); #1;
      cyc++;
    end
    start     = 1'b0;
    pix_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_strobes"}, longint'(strobe_total - s0), NACC);
    check({tag, "_pixels"}, longint'(pix_total - p0), NPIX);
    check({tag, "_done_pulses"}, longint'(done_total - d0), 1);
    check({tag, "_first_addr"}, longint'(frame_first_addr), longint'(exp_addr0));
    check({tag, "_first_data"}, longint'(frame_first_data), longint'(exp_data0));
    check({tag, "_last_data"}, longint'(frame_last_data), longint'(exp_datan));
    check({tag, "_y1_index"}, longint'(frame_y1_idx), 128);
    if (exp_run >= 0) check({tag, "_valid_run"}, longint'(max_run), longint'(exp_run));
    check({tag, "_idle_busy"}, longint'(busy), 0);
    $display("frame %s: layer=%0d strobes=%0d pixels=%0d done=%0d run=%0d cycles=%0d",
             tag, layer, strobe_total - s0, pix_total - p0, done_total - d0, max_run, cyc);
  endtask

  initial begin
    int s0, d0, cyc;
    n_rst     = 1'b0;
    start     = 1'b0;
    layer_num = 1'b0;
    pix_ready = 1'b0;
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_frame("layer0", 1'b0, 0, 1'b0, 0, 0, 255, RUN_EXP);
    run_frame("layer1", 1'b1, 0, 1'b0, L1, 24'hC00400, 24'hC004FF, RUN_EXP);
    run_frame("stall", 1'b0, 1, 1'b0, 0, 0, 255, -1);

    // Abort part way through the second access.
    s0 = strobe_total;
    d0 = done_total;
    cyc = 0;
    @(posedge clk); #1;
    layer_num = 1'b0;
    start     = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (strobe_total - s0 < 2 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reached_access2", longint'(strobe_total - s0), 2);
    repeat (5) @(posedge clk);
    #3;
    check("abort_busy_before", longint'(busy), 1);
    n_rst = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", longint'(done_total - d0), 0);
    n_rst = 1'b1;
    $display("abort: strobes=%0d before reset, done=%0d", strobe_total - s0, done_total - d0);
    repeat (2) @(posedge clk);
    #1;

    run_frame("after_abort", 1'b0, 0, 1'b0, 0, 0, 255, RUN_EXP);
    run_frame("start_busy", 1'b0, 0, 1'b1, 0, 0, 255, RUN_EXP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
